pow2_term_encoder: RTL

//  Producer side of the shift-add multiplier term interface. Accepts an unsigned operand b,

---
 rtl/pow2_term_encoder_if.sv | 29 ++
 rtl/pow2_term_encoder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pow2_term_encoder_if.sv
// Operand-in / term-beat-out bundle for pow2_term_encoder.
// master = encoder side, slave = operand source plus term consumer.
interface pow2_term_encoder_if #(
  parameter int unsigned B_W = 15,
  parameter int unsigned N   = 4
);
  logic           in_vld;
  logic           in_rdy;
  logic [B_W-1:0] b;
  logic           out_vld;
  logic           out_rdy;
  logic [N-1:0]   b_i;
  logic [N-1:0]   b_j;
  logic           one_term;
  logic           b_sign;
  logic           neg;
  logic           zero;
  logic           last;

  modport master (
    input  in_vld, b, out_rdy,
    output in_rdy, out_vld, b_i, b_j, one_term, b_sign, neg, zero, last
  );

  modport slave (
    output in_vld, b, out_rdy,
    input  in_rdy, out_vld, b_i, b_j, one_term, b_sign, neg, zero, last
  );
endinterface

// File: rtl/pow2_term_encoder.sv
// CSD recoder streaming an operand as beats of up to two power-of-two terms, MSB first.
// Optional TERM_ENC_STATS_EN adds saturating operand/beat counters.
module pow2_term_encoder #(
  parameter int unsigned B_W = 15,
  parameter int unsigned N   = 4
) (
  input  logic                clk,
  input  logic                rst,
  pow2_term_encoder_if.master bus
`ifdef TERM_ENC_STATS_EN
  ,
  output logic [15:0]         stat_ops,
  output logic [15:0]         stat_beats
`endif
);
  localparam int unsigned W = B_W + 1;

  typedef enum logic [1:0] {StIdle, StEncode, StEmit} state_e;

  state_e         state_q, state_d;
  logic [B_W-1:0] b_q;
  logic [W-1:0]   pos_mask_q, neg_mask_q;
  logic [W-1:0]   pos_mask_d, neg_mask_d;
  logic [W-1:0]   nz, clr, rem;
  logic [W:0]     x3, xe;
  logic [N-1:0]   p, q;
  logic           p_vld, q_vld;
  logic           hi_neg, lo_neg;
  logic           accept, fire;

  // NAF recoding: 3x vs x differ exactly where CSD digits are nonzero.
  always_comb begin
    xe         = {2'b00, b_q};
    x3         = {2'b00, b_q} + {1'b0, b_q, 1'b0};
    pos_mask_d = W'((x3 & ~xe) >> 1);
    neg_mask_d = W'((~x3 & xe) >> 1);
  end

  assign nz = pos_mask_q | neg_mask_q;

  // Ascending scan: p ends on the highest set digit, q on the one below it.
  always_comb begin
    p     = '0;
    q     = '0;
    p_vld = 1'b0;
    q_vld = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (nz[i]) begin
        q     = p;
        q_vld = p_vld;
        p     = N'(i);
        p_vld = 1'b1;
      end
    end
  end

  always_comb begin
    clr = '0;
    if (p_vld) clr[p] = 1'b1;
    if (q_vld) clr[q] = 1'b1;
    rem    = nz & ~clr;
    hi_neg = neg_mask_q[p];
    lo_neg = neg_mask_q[q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus.in_rdy  = 1'b0;
    bus.out_vld = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.in_rdy = 1'b1;
        if (bus.in_vld) state_d = StEncode;
      end
      StEncode: state_d = StEmit;
      StEmit: begin
        bus.out_vld = 1'b1;
        if (bus.out_rdy && (rem == '0)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept = bus.in_vld & bus.in_rdy;
  assign fire   = bus.out_vld & bus.out_rdy;

  // Beat fields decode straight from the digit masks, so they hold while stalled.
  always_comb begin
    bus.b_i      = '0;
    bus.b_j      = '0;
    bus.one_term = 1'b0;
    bus.b_sign   = 1'b0;
    bus.neg      = 1'b0;
    bus.zero     = 1'b0;
    bus.last     = 1'b0;
    if (state_q == StEmit) begin
      bus.zero = ~p_vld;
      bus.last = (rem == '0);
      bus.b_i  = p;
      bus.neg  = p_vld & hi_neg;
      if (q_vld) begin
        bus.b_j    = q;
        bus.b_sign = hi_neg ? ~lo_neg : lo_neg;
      end else begin
        bus.one_term = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q        <= '0;
      pos_mask_q <= '0;
      neg_mask_q <= '0;
    end else begin
      if (accept) b_q <= bus.b;
      if (state_q == StEncode) begin
        pos_mask_q <= pos_mask_d;
        neg_mask_q <= neg_mask_d;
      end else if (fire) begin
        pos_mask_q <= pos_mask_q & ~clr;
        neg_mask_q <= neg_mask_q & ~clr;
      end
    end
  end

`ifdef TERM_ENC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_beats <= '0;
    end else begin
      if (accept && (stat_ops != 16'hFFFF)) stat_ops <= stat_ops + 16'd1;
      if (fire && (stat_beats != 16'hFFFF)) stat_beats <= stat_beats + 16'd1;
    end
  end
`endif

endmodule
